// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - Shared memory-array interface; controller-side nets are tri so several controllers can share them
// Signals:
//   Addr, DataIn, rdEn, wrEn - driven by whichever controller owns the current burst, 'z otherwise
//   DataOut                  - read data from the array, valid the cycle after rdEn
interface memArray_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
);
    tri   [AWIDTH-1:0] Addr;
    tri   [DWIDTH-1:0] DataIn;
    tri                rdEn;
    tri                wrEn;
    logic [DWIDTH-1:0] DataOut;

    modport MemIF   (output Addr, DataIn, rdEn, wrEn, input DataOut);
    modport ArrayIF (input Addr, DataIn, rdEn, wrEn, output DataOut);
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - Paged 4-beat burst controller between a muxed address/data bus and a shared memory array
// Ports:
//   clk          - clock, all state on rising edge
//   resetN       - asynchronous active-low reset
//   AddrValid    - one-cycle strobe marking the address cycle
//   rw           - 1 = read, 0 = write, sampled with AddrValid
//   AddrData_in  - address in the address cycle, write data in data cycles
//   AddrData_out - read data returned to the bus (holds last value when not enabled)
//   AddrData_oe  - high while AddrData_out must drive the bus
//   mem          - memory array port; all controller-driven nets released to 'z when idle
module mem_ctrl #(
    parameter logic [3:0] BASEADDR  = 4'h0,
    parameter int         ADDRWIDTH = 12,
    parameter int         BUSWIDTH  = 16
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                AddrValid,
    input  logic                rw,
    input  logic [BUSWIDTH-1:0] AddrData_in,
    output logic [BUSWIDTH-1:0] AddrData_out,
    output logic                AddrData_oe,
    memArray_if.MemIF           mem
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] RDDRAIN = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           r_beat;
    logic [ADDRWIDTH-1:0] r_base;
    logic                 r_oe;
    logic [BUSWIDTH-1:0]  r_last;

    logic                 w_sel;
    logic                 w_active;
    logic [1:0]           w_col;
    logic [ADDRWIDTH-1:0] w_addr;

    assign w_sel    = AddrValid && (AddrData_in[15:12] == BASEADDR);
    assign w_active = (r_state == WRITE) || (r_state == READ);

    // The low two address bits advance modulo 4 so a burst wraps inside its aligned 4-word block.
    assign w_col  = r_base[1:0] + r_beat;
    assign w_addr = {r_base[ADDRWIDTH-1:2], w_col};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_base  <= '0;
            r_oe    <= 1'b0;
            r_last  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel) begin
                        r_base  <= AddrData_in[ADDRWIDTH-1:0];
                        r_beat  <= 2'd0;
                        r_state <= rw ? READ : WRITE;
                    end
                end
                WRITE: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) r_state <= IDLE;
                end
                READ: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) r_state <= RDDRAIN;
                end
                default: r_state <= IDLE;
            endcase

            // Array data lags rdEn by one cycle, so the output window is the read window shifted by one.
            r_oe <= (r_state == READ);
            if (r_oe) r_last <= mem.DataOut;
        end
    end

    // The array's output register supplies the word during the window; r_last keeps it afterwards.
    assign AddrData_out = r_oe ? mem.DataOut : r_last;
    assign AddrData_oe  = r_oe;

    assign mem.Addr   = w_active ? w_addr : 'z;
    assign mem.DataIn = w_active ? AddrData_in : 'z;
    assign mem.rdEn   = w_active ? (r_state == READ) : 1'bz;
    assign mem.wrEn   = w_active ? (r_state == WRITE) : 1'bz;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - Scoreboard bench: two mem_ctrl pages sharing one memory array
module tb_mem_ctrl;
    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        AddrValid;
    logic        rw;
    logic [15:0] AddrData_in;
    logic [15:0] out2, out3;
    logic        oe2, oe3;

    memArray_if m ();

    always #5 clk = ~clk;

    mem_ctrl #(.BASEADDR(4'h2)) dut2 (
        .clk(clk), .resetN(resetN), .AddrValid(AddrValid), .rw(rw),
        .AddrData_in(AddrData_in), .AddrData_out(out2), .AddrData_oe(oe2), .mem(m)
    );
    mem_ctrl #(.BASEADDR(4'h3)) dut3 (
        .clk(clk), .resetN(resetN), .AddrValid(AddrValid), .rw(rw),
        .AddrData_in(AddrData_in), .AddrData_out(out3), .AddrData_oe(oe3), .mem(m)
    );

    logic [15:0] mem_arr [4096];
    logic [15:0] shadow  [4096];

    always @(posedge clk) begin
        if (m.wrEn === 1'b1) mem_arr[m.Addr] <= m.DataIn;
        if (m.rdEn === 1'b1) m.DataOut <= mem_arr[m.Addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    wr_t         wr_q  [$];
    logic [11:0] ra_q  [$];
    logic [15:0] rd2_q [$];
    logic [15:0] rd3_q [$];
    logic [11:0] blk_q [$];
    wr_t         mon_w;
    logic [11:0] mon_a;
    logic [15:0] mon_d;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m.wrEn === 1'b1) begin
                check_eq("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check_eq("wr_addr", m.Addr, mon_w.a);
                    check_eq("wr_data", m.DataIn, mon_w.d);
                end
            end
            if (m.rdEn === 1'b1) begin
                check_eq("rd_expected", ra_q.size() != 0, 1);
                if (ra_q.size() != 0) begin
                    mon_a = ra_q.pop_front();
                    check_eq("rd_addr", m.Addr, mon_a);
                end
            end
            if (oe2) begin
                check_eq("rd2_expected", rd2_q.size() != 0, 1);
                if (rd2_q.size() != 0) begin
                    mon_d = rd2_q.pop_front();
                    check_eq("rd2_data", out2, mon_d);
                end
            end
            if (oe3) begin
                check_eq("rd3_expected", rd3_q.size() != 0, 1);
                if (rd3_q.size() != 0) begin
                    mon_d = rd3_q.pop_front();
                    check_eq("rd3_data", out3, mon_d);
                end
            end
            check_eq("single_driver", dut2.w_active && dut3.w_active, 0);
            check_eq("rd_wr_excl", (m.rdEn === 1'b1) && (m.wrEn === 1'b1), 0);
            check_eq("en_not_x", (m.rdEn === 1'bx) || (m.wrEn === 1'bx), 0);
        end
    end

    task automatic write_burst(input logic [15:0] addr, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        logic [1:0]  col;
        logic [11:0] a;
        logic [3:0]  pg;
        bit          hit;
        d   = '{d0, d1, d2, d3};
        pg  = addr[15:12];
        hit = (pg == 4'h2) || (pg == 4'h3);
        AddrValid = 1'b1; rw = 1'b0; AddrData_in = addr;
        if (hit) begin
            for (int i = 0; i < 4; i++) begin
                col = addr[1:0] + 2'(i);
                a   = {addr[11:2], col};
                wr_q.push_back('{a, d[i]});
                shadow[a] = d[i];
            end
            blk_q.push_back({addr[11:2], 2'b00});
        end
        @(negedge clk);
        check_eq("wr_acyc_idle", dut2.w_active || dut3.w_active, 0);
        @(posedge clk); #1;
        AddrValid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            AddrData_in = d[c-1];
            @(negedge clk);
            check_eq("wr_en", m.wrEn === 1'b1, hit);
            check_eq("wr_rden_low", m.rdEn === 1'b1, 0);
            check_eq("wr_active2", dut2.w_active, pg == 4'h2);
            check_eq("wr_active3", dut3.w_active, pg == 4'h3);
            check_eq("wr_oe", oe2 || oe3, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic read_burst(input logic [15:0] addr, input bit chain_av, input logic [15:0] chain_addr);
        logic [1:0]  col;
        logic [11:0] a;
        logic [3:0]  pg;
        bit          hit;
        pg  = addr[15:12];
        hit = (pg == 4'h2) || (pg == 4'h3);
        AddrValid = 1'b1; rw = 1'b1; AddrData_in = addr;
        if (hit) begin
            for (int i = 0; i < 4; i++) begin
                col = addr[1:0] + 2'(i);
                a   = {addr[11:2], col};
                ra_q.push_back(a);
                if (pg == 4'h2) rd2_q.push_back(shadow[a]);
                else            rd3_q.push_back(shadow[a]);
            end
        end
        @(negedge clk);
        check_eq("rd_acyc_idle", dut2.w_active || dut3.w_active, 0);
        @(posedge clk); #1;
        AddrValid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5 && chain_av) begin
                AddrValid = 1'b1; rw = 1'b1; AddrData_in = chain_addr;
            end
            @(negedge clk);
            check_eq("rd_en", m.rdEn === 1'b1, hit && c <= 4);
            check_eq("rd_wren_low", m.wrEn === 1'b1, 0);
            check_eq("rd_active2", dut2.w_active, pg == 4'h2 && c <= 4);
            check_eq("rd_active3", dut3.w_active, pg == 4'h3 && c <= 4);
            check_eq("rd_oe2", oe2, pg == 4'h2 && c >= 2);
            check_eq("rd_oe3", oe3, pg == 4'h3 && c >= 2);
            @(posedge clk); #1;
            AddrValid = 1'b0;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_active", dut2.w_active || dut3.w_active, 0);
            check_eq("idle_en", (m.rdEn === 1'b1) || (m.wrEn === 1'b1), 0);
            check_eq("idle_oe", oe2 || oe3, 0);
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] ra;
    logic [3:0]  pg;
    logic [11:0] blk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; AddrValid = 1'b0; rw = 1'b0; AddrData_in = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_oe2", oe2, 0);
        check_eq("rst_oe3", oe3, 0);
        check_eq("rst_out2", out2, 16'h0);
        check_eq("rst_out3", out3, 16'h0);
        check_eq("rst_active", dut2.w_active || dut3.w_active, 0);
        check_eq("rst_en", (m.rdEn === 1'b1) || (m.wrEn === 1'b1), 0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Release and present AddrValid for the very next edge, then a back-to-back write.
        resetN = 1'b1;
        write_burst(16'h2010, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
        write_burst(16'h2FFE, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        // Read with an AddrValid in cycle 5 that must be ignored, then one in cycle 6 that is taken.
        read_burst(16'h2010, 1'b1, 16'h2FFC);
        read_burst(16'h2FFC, 1'b0, 16'h0);
        @(negedge clk);
        check_eq("hold_out2", out2, 16'h0022);
        check_eq("hold_oe2", oe2, 0);
        @(posedge clk); #1;

        // Unaddressed page, then the neighbouring page.
        write_burst(16'h5010, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD);
        idle_check(2);
        write_burst(16'h3010, 16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4);
        read_burst(16'h3012, 1'b0, 16'h0);
        read_burst(16'h2011, 1'b0, 16'h0);

        // Reset in cycle 3 of a read.
        AddrValid = 1'b1; rw = 1'b1; AddrData_in = 16'h2010;
        for (int i = 0; i < 4; i++) begin
            ra_q.push_back(12'h010 + 12'(i));
            rd2_q.push_back(shadow[12'h010 + 12'(i)]);
        end
        @(posedge clk); #1;
        AddrValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        check_eq("abort_active2", dut2.w_active, 0);
        check_eq("abort_rden", m.rdEn === 1'b1, 0);
        check_eq("abort_oe2", oe2, 0);
        check_eq("abort_out2", out2, 16'h0);
        check_eq("abort_ra_left", ra_q.size(), 2);
        check_eq("abort_rd_left", rd2_q.size(), 3);
        ra_q.delete();
        rd2_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        idle_check(6);
        write_burst(16'h2020, 16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4);
        read_burst(16'h2023, 1'b0, 16'h0);

        for (int t = 0; t < 12; t++) begin
            pg = 4'($urandom_range(1, 4));
            if (blk_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                ra = {pg, 12'($urandom_range(0, 4095))};
                write_burst(ra, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end else begin
                blk = blk_q[$urandom_range(0, blk_q.size() - 1)];
                ra  = {pg, blk[11:2], 2'($urandom_range(0, 3))};
                read_burst(ra, 1'b0, 16'h0);
            end
        end

        idle_check(2);
        check_eq("wr_q_drained", wr_q.size(), 0);
        check_eq("ra_q_drained", ra_q.size(), 0);
        check_eq("rd2_q_drained", rd2_q.size(), 0);
        check_eq("rd3_q_drained", rd3_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter BASEADDR, default 4'h0, selects which 4K page of the 16-bit bus address this controller serves.
REQ-002 Parameter ADDRWIDTH, default 12, gives the memory array address width.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port resetN, input, 1, reset; asynchronous, active-low.
REQ-005 Port AddrValid, input, 1, high for exactly one cycle to mark the address cycle of a bus transaction.
REQ-006 Port rw, input, 1, sampled with AddrValid: 1 = read, 0 = write.
REQ-007 Port AddrData_in, input, BUSWIDTH, carries the address in the address cycle and write data in data cycles.
REQ-008 Port AddrData_out, output, BUSWIDTH, carries read data returned to the bus.
REQ-009 Port AddrData_oe, output, 1, high only when AddrData_out must drive the bus.
REQ-010 Port mem, memArray_if.MemIF modport, drives Addr, DataIn, rdEn and wrEn, and receives DataOut.

Function
REQ-011 Select: in IDLE with AddrValid=1, the block SHALL accept the transaction only if AddrData_in[15:12]==BASEADDR; otherwise it stays IDLE.
REQ-012 On accept, the block SHALL register base = AddrData_in[ADDRWIDTH-1:0] and rw, clear the 2-bit beat counter, and go to WRITE (rw=0) or READ (rw=1).
REQ-013 Each transaction SHALL be a 4-beat burst; beat i SHALL use Addr = {base[ADDRWIDTH-1:2], (base[1:0]+i) mod 4}, wrapping within the aligned 4-word block.
REQ-014 WRITE: in data cycles 1..4 after the address cycle, the block SHALL drive wrEn=1, rdEn=0, DataIn=AddrData_in (combinational from bus) and Addr for beat 0..3.
REQ-015 After beat 3 of a write, the block SHALL return to IDLE; an AddrValid in cycle 5 SHALL be accepted (back-to-back).
REQ-016 READ: in cycles 1..4 the block SHALL drive rdEn=1, wrEn=0 and Addr for beat 0..3; the array returns DataOut one cycle after rdEn.
REQ-017 Read data SHALL be registered and presented on AddrData_out with AddrData_oe=1 in cycles 2..5 (word for beat 0..3).
REQ-018 The FSM SHALL have states IDLE, WRITE, READ and RDDRAIN; READ goes to RDDRAIN after beat 3; RDDRAIN (cycle 5) outputs the last word and goes to IDLE, so the next AddrValid is accepted in cycle 6.
REQ-019 AddrValid asserted while not in IDLE SHALL be ignored and SHALL NOT disturb the burst in progress.
REQ-020 While a transaction is not in progress, including every IDLE cycle, mem.Addr, mem.DataIn, mem.rdEn and mem.wrEn SHALL be driven 'z, allowing several controllers to share the tri nets.
REQ-021 During WRITE and READ, rdEn and wrEn SHALL never both be 1; in RDDRAIN both SHALL be 'z.
REQ-022 AddrData_oe SHALL be 0 in IDLE and WRITE; AddrData_out SHALL hold its last value when oe=0.

Reset
REQ-023 On resetN low, asynchronously: state=IDLE, beat counter=0, base=0, AddrData_out=0, AddrData_oe=0, and mem outputs 'z.
REQ-024 A reset during a burst SHALL abort it immediately with no further rdEn/wrEn; after release, the block waits for a new AddrValid.
REQ-025 In the first clk edge after resetN deasserts, the block SHALL accept an AddrValid.

Verification
REQ-026 BASEADDR=2, write at 16'h2010 with data A1,A2,A3,A4 -> wrEn in cycles 1-4, Addr 010,011,012,013 with matching DataIn; a read of 16'h2010 then returns A1-A4 in cycles 2-5 with oe=1.
REQ-027 Wrap: write at 16'h2FFE -> Addr FFE,FFF,FFC,FFD; a read of 16'h2FFC returns words 3,4,1,2.
REQ-028 Unselected: BASEADDR=2, AddrValid with 16'h3010 -> mem outputs stay 'z and oe=0 for 6 cycles.
REQ-029 Back-to-back: a write then AddrValid in cycle 5 -> accepted; a read then AddrValid in cycle 5 -> ignored, while AddrValid in cycle 6 -> accepted.
REQ-030 Reset mid-read: resetN low in cycle 3 -> rdEn goes 'z and oe=0 asynchronously; no further data after release.
REQ-031 Two instances (BASEADDR 2 and 3) on one memArray_if -> only the addressed instance drives the nets; no X on rdEn/wrEn in any cycle.
